// File: rtl/ft600_fifo_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : ft600_fifo_emulator_if
// Description : FT600 245-FIFO bus plus host AXI-stream ports of the emulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface ft600_fifo_emulator_if;
    // chip-side 245 synchronous FIFO bus
    logic        ftdi_rxf_n;
    logic        ftdi_txe_n;
    logic        ftdi_oe_n;
    logic        ftdi_rd_n;
    logic        ftdi_wr_n;
    logic [15:0] ftdi_data_i;
    logic [1:0]  ftdi_be_i;
    logic [15:0] ftdi_data_o;
    logic [1:0]  ftdi_be_o;
    logic        ftdi_bus_oe;
    // host-side streams
    logic        host_in_tvalid;
    logic        host_in_tready;
    logic [15:0] host_in_tdata;
    logic [1:0]  host_in_tkeep;
    logic        host_out_tvalid;
    logic        host_out_tready;
    logic [15:0] host_out_tdata;
    logic [1:0]  host_out_tkeep;
    // status
    logic [31:0] rd_words;
    logic [31:0] wr_words;
    logic        rd_err;
    logic        wr_err;
    logic        bus_err;

    modport slave (
        output ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_be_o, ftdi_bus_oe,
        input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i, ftdi_be_i,
        input  host_in_tvalid, host_in_tdata, host_in_tkeep, host_out_tready,
        output host_in_tready, host_out_tvalid, host_out_tdata, host_out_tkeep,
        output rd_words, wr_words, rd_err, wr_err, bus_err
    );

    modport master (
        input  ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_be_o, ftdi_bus_oe,
        output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i, ftdi_be_i,
        output host_in_tvalid, host_in_tdata, host_in_tkeep, host_out_tready,
        input  host_in_tready, host_out_tvalid, host_out_tdata, host_out_tkeep,
        input  rd_words, wr_words, rd_err, wr_err, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/ft600_fifo_emulator.sv
`default_nettype none
// ============================================================================
// Module      : ft600_fifo_emulator
// Description : FT600 chip-side model of the 245 sync FIFO bus with FWFT
//               down (host->FPGA) and up (FPGA->host) buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module ft600_fifo_emulator #(
    parameter int DN_EA = 4,
    parameter int UP_EA = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ft600_fifo_emulator_if.slave bus
);

    localparam logic [DN_EA:0] c_DN_FULL = {1'b1, {DN_EA{1'b0}}};
    localparam logic [UP_EA:0] c_UP_FULL = {1'b1, {UP_EA{1'b0}}};

    logic [17:0]      r_dn_mem [1 << DN_EA];
    logic [DN_EA-1:0] r_dn_wr_ptr;
    logic [DN_EA-1:0] r_dn_rd_ptr;
    logic [DN_EA:0]   r_dn_count;
    logic [DN_EA:0]   w_dn_count_next;
    logic [17:0]      w_dn_head;
    logic             w_dn_push;
    logic             w_rd_fire;

    logic [17:0]      r_up_mem [1 << UP_EA];
    logic [UP_EA-1:0] r_up_wr_ptr;
    logic [UP_EA-1:0] r_up_rd_ptr;
    logic [UP_EA:0]   r_up_count;
    logic [UP_EA:0]   w_up_count_next;
    logic [17:0]      w_up_head;
    logic             w_up_pop;
    logic             w_wr_fire;

    logic             r_rxf_n;
    logic             r_txe_n;
    logic [31:0]      r_rd_words;
    logic [31:0]      r_wr_words;
    logic             r_rd_err;
    logic             r_wr_err;
    logic             r_bus_err;

    // Fire conditions use the registered flags, exactly what the controller sees.
    assign bus.host_in_tready = ~rst & (r_dn_count != c_DN_FULL);
    assign w_dn_push          = bus.host_in_tvalid & bus.host_in_tready;
    assign w_rd_fire          = ~bus.ftdi_oe_n & ~bus.ftdi_rd_n & ~r_rxf_n;
    assign w_wr_fire          = ~bus.ftdi_wr_n & ~r_txe_n;
    assign w_up_pop           = (r_up_count != '0) & bus.host_out_tready;

    assign w_dn_count_next = r_dn_count + {{DN_EA{1'b0}}, w_dn_push}
                                        - {{DN_EA{1'b0}}, w_rd_fire};
    assign w_up_count_next = r_up_count + {{UP_EA{1'b0}}, w_wr_fire}
                                        - {{UP_EA{1'b0}}, w_up_pop};

    assign w_dn_head = r_dn_mem[r_dn_rd_ptr];
    assign w_up_head = r_up_mem[r_up_rd_ptr];

    assign bus.ftdi_data_o     = (r_dn_count != '0) ? w_dn_head[15:0]  : 16'h0000;
    assign bus.ftdi_be_o       = (r_dn_count != '0) ? w_dn_head[17:16] : 2'b00;
    assign bus.ftdi_bus_oe     = ~bus.ftdi_oe_n;
    assign bus.ftdi_rxf_n      = r_rxf_n;
    assign bus.ftdi_txe_n      = r_txe_n;

    assign bus.host_out_tvalid = (r_up_count != '0);
    assign bus.host_out_tdata  = (r_up_count != '0) ? w_up_head[15:0]  : 16'h0000;
    assign bus.host_out_tkeep  = (r_up_count != '0) ? w_up_head[17:16] : 2'b00;

    assign bus.rd_words = r_rd_words;
    assign bus.wr_words = r_wr_words;
    assign bus.rd_err   = r_rd_err;
    assign bus.wr_err   = r_wr_err;
    assign bus.bus_err  = r_bus_err;

    // Storage arrays carry no reset so they map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_dn_push) begin
            r_dn_mem[r_dn_wr_ptr] <= {bus.host_in_tkeep, bus.host_in_tdata};
        end
        if (w_wr_fire) begin
            r_up_mem[r_up_wr_ptr] <= {bus.ftdi_be_i, bus.ftdi_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dn_wr_ptr <= '0;
            r_dn_rd_ptr <= '0;
            r_dn_count  <= '0;
            r_up_wr_ptr <= '0;
            r_up_rd_ptr <= '0;
            r_up_count  <= '0;
            r_rxf_n     <= 1'b1;
            r_txe_n     <= 1'b1;
            r_rd_words  <= '0;
            r_wr_words  <= '0;
            r_rd_err    <= 1'b0;
            r_wr_err    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_dn_push) r_dn_wr_ptr <= r_dn_wr_ptr + 1'b1;
            if (w_rd_fire) r_dn_rd_ptr <= r_dn_rd_ptr + 1'b1;
            if (w_wr_fire) r_up_wr_ptr <= r_up_wr_ptr + 1'b1;
            if (w_up_pop)  r_up_rd_ptr <= r_up_rd_ptr + 1'b1;
            r_dn_count <= w_dn_count_next;
            r_up_count <= w_up_count_next;
            r_rxf_n    <= (w_dn_count_next == '0);
            r_txe_n    <= (w_up_count_next == c_UP_FULL);
            if (w_rd_fire) r_rd_words <= r_rd_words + 32'd1;
            if (w_wr_fire) r_wr_words <= r_wr_words + 32'd1;
            if (~bus.ftdi_oe_n & ~bus.ftdi_rd_n & r_rxf_n) r_rd_err  <= 1'b1;
            if (~bus.ftdi_wr_n & r_txe_n)                   r_wr_err  <= 1'b1;
            if (~bus.ftdi_oe_n & ~bus.ftdi_wr_n)            r_bus_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ft600_fifo_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft600_fifo_emulator
// Description : Directed self-checking bench for ft600_fifo_emulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ft600_fifo_emulator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ft600_fifo_emulator_if bus ();

    ft600_fifo_emulator #(.DN_EA(4), .UP_EA(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        tvalid;
        logic [15:0] tdata;
        logic [1:0]  tkeep;
        logic        oe_n;
        logic        rd_n;
        logic        exp_rxf_n;
        logic        exp_txe_n;
        logic        exp_tready;
        logic        exp_bus_oe;
        logic [15:0] exp_data;
        logic [1:0]  exp_be;
        logic [31:0] exp_rd_words;
        logic        exp_rd_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst                 = 1'b1;
        bus.host_in_tvalid  = 1'b0;
        bus.host_in_tdata   = 16'h0;
        bus.host_in_tkeep   = 2'b0;
        bus.host_out_tready = 1'b0;
        bus.ftdi_oe_n       = 1'b1;
        bus.ftdi_rd_n       = 1'b1;
        bus.ftdi_wr_n       = 1'b1;
        bus.ftdi_data_i     = 16'h0;
        bus.ftdi_be_i       = 2'b0;

        // reset, release, two host pushes, two bus reads, idle
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 32'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 32'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 32'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 32'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h1234, 2'd3, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 2'd3, 32'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'hABCD, 2'd1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 2'd3, 32'd0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD, 2'd1, 32'd1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 2'd0, 32'd2, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 32'd2, 1'b0};

        for (int i = 0; i < 9; i++) begin
            rst                = vecs[i].rst;
            bus.host_in_tvalid = vecs[i].tvalid;
            bus.host_in_tdata  = vecs[i].tdata;
            bus.host_in_tkeep  = vecs[i].tkeep;
            bus.ftdi_oe_n      = vecs[i].oe_n;
            bus.ftdi_rd_n      = vecs[i].rd_n;
            tick();
            chk($sformatf("v%0d rxf_n", i),    32'(bus.ftdi_rxf_n),     32'(vecs[i].exp_rxf_n));
            chk($sformatf("v%0d txe_n", i),    32'(bus.ftdi_txe_n),     32'(vecs[i].exp_txe_n));
            chk($sformatf("v%0d tready", i),   32'(bus.host_in_tready), 32'(vecs[i].exp_tready));
            chk($sformatf("v%0d bus_oe", i),   32'(bus.ftdi_bus_oe),    32'(vecs[i].exp_bus_oe));
            chk($sformatf("v%0d data_o", i),   32'(bus.ftdi_data_o),    32'(vecs[i].exp_data));
            chk($sformatf("v%0d be_o", i),     32'(bus.ftdi_be_o),      32'(vecs[i].exp_be));
            chk($sformatf("v%0d rd_words", i), bus.rd_words,            vecs[i].exp_rd_words);
            chk($sformatf("v%0d rd_err", i),   32'(bus.rd_err),         32'(vecs[i].exp_rd_err));
            chk($sformatf("v%0d wr_words", i), bus.wr_words,            32'd0);
            chk($sformatf("v%0d wr_err", i),   32'(bus.wr_err),         32'd0);
            chk($sformatf("v%0d bus_err", i),  32'(bus.bus_err),        32'd0);
            chk($sformatf("v%0d out_tvalid", i), 32'(bus.host_out_tvalid), 32'd0);
        end
        bus.ftdi_oe_n = 1'b1;
        bus.ftdi_rd_n = 1'b1;

        // down FIFO fill to 16, 17th word refused, then ordered drain
        for (int i = 0; i < 16; i++) begin
            bus.host_in_tvalid = 1'b1;
            bus.host_in_tdata  = 16'h0100 + 16'(i);
            bus.host_in_tkeep  = 2'(i);
            tick();
        end
        chk("dn_full tready", 32'(bus.host_in_tready), 32'd0);
        chk("dn_full rxf_n",  32'(bus.ftdi_rxf_n),     32'd0);
        bus.host_in_tdata = 16'hDEAD;
        tick();
        bus.host_in_tvalid = 1'b0;
        bus.ftdi_oe_n = 1'b0;
        bus.ftdi_rd_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("dn_drain data %0d", i), 32'(bus.ftdi_data_o), 32'h0100 + 32'(i));
            chk($sformatf("dn_drain be %0d", i),   32'(bus.ftdi_be_o),   32'(i % 4));
            tick();
        end
        bus.ftdi_oe_n = 1'b1;
        bus.ftdi_rd_n = 1'b1;
        chk("dn_drain rxf_n",    32'(bus.ftdi_rxf_n),     32'd1);
        chk("dn_drain rd_words", bus.rd_words,            32'd18);
        chk("dn_drain tready",   32'(bus.host_in_tready), 32'd1);
        tick();
        chk("dn_drain rd_err",   32'(bus.rd_err),         32'd0);

        // up FIFO fill, then one host pop reopens TXE_N
        bus.ftdi_wr_n = 1'b0;
        bus.ftdi_be_i = 2'd3;
        for (int i = 0; i < 16; i++) begin
            bus.ftdi_data_i = 16'(i);
            chk($sformatf("up_fill txe_n %0d", i), 32'(bus.ftdi_txe_n), 32'd0);
            tick();
        end
        bus.ftdi_wr_n = 1'b1;
        chk("up_full txe_n",    32'(bus.ftdi_txe_n),      32'd1);
        chk("up_full wr_words", bus.wr_words,             32'd16);
        chk("up_full tvalid",   32'(bus.host_out_tvalid), 32'd1);
        chk("up_full tdata",    32'(bus.host_out_tdata),  32'h0000);
        chk("up_full tkeep",    32'(bus.host_out_tkeep),  32'd3);
        bus.host_out_tready = 1'b1;
        tick();
        bus.host_out_tready = 1'b0;
        chk("up_pop txe_n",     32'(bus.ftdi_txe_n),      32'd0);
        chk("up_pop tdata",     32'(bus.host_out_tdata),  32'h0001);

        // refill to full, then the three violations
        bus.ftdi_wr_n   = 1'b0;
        bus.ftdi_data_i = 16'h0010;
        tick();
        chk("refill txe_n",    32'(bus.ftdi_txe_n), 32'd1);
        chk("refill wr_words", bus.wr_words,        32'd17);
        bus.ftdi_data_i = 16'hBEEF;
        tick();
        bus.ftdi_wr_n = 1'b1;
        chk("wr_err set",      32'(bus.wr_err),     32'd1);
        chk("wr_err wr_words", bus.wr_words,        32'd17);
        chk("wr_err bus_err",  32'(bus.bus_err),    32'd0);
        bus.ftdi_oe_n = 1'b0;
        bus.ftdi_wr_n = 1'b0;
        tick();
        bus.ftdi_oe_n = 1'b1;
        bus.ftdi_wr_n = 1'b1;
        chk("bus_err set",     32'(bus.bus_err),    32'd1);
        chk("bus_err rd_err",  32'(bus.rd_err),     32'd0);
        bus.ftdi_oe_n = 1'b0;
        bus.ftdi_rd_n = 1'b0;
        tick();
        bus.ftdi_oe_n = 1'b1;
        bus.ftdi_rd_n = 1'b1;
        chk("rd_err set",      32'(bus.rd_err),     32'd1);
        chk("rd_err rd_words", bus.rd_words,        32'd18);
        chk("rd_err rxf_n",    32'(bus.ftdi_rxf_n), 32'd1);
        repeat (3) tick();
        chk("sticky rd_err",  32'(bus.rd_err),  32'd1);
        chk("sticky wr_err",  32'(bus.wr_err),  32'd1);
        chk("sticky bus_err", 32'(bus.bus_err), 32'd1);

        // drain: words 1..15 then 0x10; 0xBEEF must be absent
        bus.host_out_tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("up_drain tvalid %0d", i), 32'(bus.host_out_tvalid), 32'd1);
            chk($sformatf("up_drain tdata %0d", i),  32'(bus.host_out_tdata),  32'(i));
            tick();
        end
        bus.host_out_tready = 1'b0;
        chk("up_drain empty", 32'(bus.host_out_tvalid), 32'd0);
        chk("up_drain txe_n", 32'(bus.ftdi_txe_n),      32'd0);

        // simultaneous write and host pop at a depth of 8
        bus.ftdi_wr_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.ftdi_data_i = 16'h0200 + 16'(i);
            tick();
        end
        bus.host_out_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.ftdi_data_i = 16'h0208 + 16'(k);
            chk($sformatf("simul tdata %0d", k), 32'(bus.host_out_tdata), 32'h0200 + 32'(k));
            chk($sformatf("simul txe_n %0d", k), 32'(bus.ftdi_txe_n),     32'd0);
            tick();
        end
        bus.ftdi_wr_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("simul tail %0d", k), 32'(bus.host_out_tdata), 32'h0214 + 32'(k));
            tick();
        end
        bus.host_out_tready = 1'b0;
        chk("simul empty",    32'(bus.host_out_tvalid), 32'd0);
        chk("simul wr_words", bus.wr_words,             32'd45);

        // reset in the middle of buffered traffic discards everything
        bus.host_in_tvalid = 1'b1;
        bus.ftdi_wr_n      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.host_in_tdata = 16'h0300 + 16'(i);
            bus.ftdi_data_i   = 16'h0400 + 16'(i);
            tick();
        end
        bus.host_in_tvalid = 1'b0;
        bus.ftdi_wr_n      = 1'b1;
        chk("pre_rst rxf_n",  32'(bus.ftdi_rxf_n),      32'd0);
        rst = 1'b1;
        tick();
        chk("rst rxf_n",      32'(bus.ftdi_rxf_n),      32'd1);
        chk("rst txe_n",      32'(bus.ftdi_txe_n),      32'd1);
        chk("rst tready",     32'(bus.host_in_tready),  32'd0);
        chk("rst rd_words",   bus.rd_words,             32'd0);
        chk("rst wr_words",   bus.wr_words,             32'd0);
        chk("rst errs",       {29'd0, bus.rd_err, bus.wr_err, bus.bus_err}, 32'd0);
        chk("rst out_tvalid", 32'(bus.host_out_tvalid), 32'd0);
        chk("rst data_o",     32'(bus.ftdi_data_o),     32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst rxf_n",  32'(bus.ftdi_rxf_n),      32'd1);
        chk("post_rst txe_n",  32'(bus.ftdi_txe_n),      32'd0);
        chk("post_rst tvalid", 32'(bus.host_out_tvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
